// File: rtl/vga_sync_pkg.sv
// Shared types and default timing for the VGA sync decoder.
// Defaults describe the 682x524 scan-doubled output timing.
package vga_sync_pkg;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lock_state_e;

  localparam int CNT_W_DEF       = 11;
  localparam int H_TOTAL_DEF     = 682;
  localparam int V_TOTAL_DEF     = 524;
  localparam int H_BP_DEF        = 32;
  localparam int V_BP_DEF        = 32;
  localparam int H_ACTIVE_DEF    = 512;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int H_SYNC_DEF      = 80;
  localparam int V_SYNC_DEF      = 2;
  localparam int LOCK_FRAMES_DEF = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync input plus a one-cycle
// pulse on its trailing (rising) edge.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sync_n,
  output logic pulse
);

  logic s1, s2, prev;

  // Flops reset high so an idle (high) input never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= sync_n;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers line/frame position, active window and lock state from an
// active-low HSYNC/VSYNC pair by measuring line length and frame height.
module vga_sync_decoder
  import vga_sync_pkg::*;
#(
  parameter int H_BACKPORCH = H_BP_DEF,
  parameter int V_BACKPORCH = V_BP_DEF,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync_n,
  input  logic             vsync_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             new_line,
  output logic             new_frame,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_BACKPORCH);
  localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_BACKPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_BACKPORCH);
  localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_BACKPORCH + V_ACTIVE);

  logic             h_edge, v_edge;
  logic [CNT_W-1:0] hpos, vpos, hpos_nxt, vpos_nxt, hlen, vlen;
  logic [CNT_W-1:0] ref_len, ref_lines;
  logic [MW-1:0]    match_cnt;
  logic             skip_len, line_bad, frame_bad, sat, go_lock, lock_nxt, win_nxt;
  lock_state_e      state;

  sync_edge_detect u_hs (.clk(clk), .reset(reset), .sync_n(hsync_n), .pulse(h_edge));
  sync_edge_detect u_vs (.clk(clk), .reset(reset), .sync_n(vsync_n), .pulse(v_edge));

  assign hlen = hpos + CNT_W'(1);
  assign vlen = vpos + CNT_W'(1);

  always_comb begin
    hpos_nxt = hpos;
    if (h_edge)            hpos_nxt = '0;
    else if (hpos != CMAX) hpos_nxt = hlen;
    vpos_nxt = vpos;
    if (v_edge)                      vpos_nxt = '0;
    else if (h_edge && vpos != CMAX) vpos_nxt = vlen;
  end

  // The line ending right after a VSYNC edge may be partial, so skip its check.
  assign line_bad  = h_edge & ~skip_len & (hlen != ref_len);
  assign frame_bad = v_edge & (vlen != ref_lines);
  assign sat       = (hpos_nxt == CMAX) | (vpos_nxt == CMAX);
  // Lock needs LOCK_FRAMES matches already counted plus one more clean frame.
  assign go_lock   = (state == VERIFY) & v_edge & ~line_bad & ~frame_bad &
                     (match_cnt >= MW'(LOCK_FRAMES));
  assign lock_nxt  = go_lock | ((state == LOCKED) & ~(line_bad | frame_bad | sat));
  assign win_nxt   = (hpos_nxt >= H_LO) && (hpos_nxt < H_HI) &&
                     (vpos_nxt >= V_LO) && (vpos_nxt < V_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      locked      <= 1'b0;
      new_line    <= 1'b0;
      new_frame   <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      skip_len    <= 1'b0;
    end else begin
      hpos      <= hpos_nxt;
      vpos      <= vpos_nxt;
      x         <= hpos_nxt - H_LO;
      y         <= vpos_nxt - V_LO;
      active    <= win_nxt & lock_nxt;
      locked    <= lock_nxt;
      new_line  <= h_edge;
      new_frame <= v_edge;
      if (h_edge) line_len    <= hlen;
      if (v_edge) frame_lines <= vlen;
      if (v_edge)      skip_len <= 1'b1;
      else if (h_edge) skip_len <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      ref_len   <= '0;
      ref_lines <= '0;
      match_cnt <= '0;
    end else begin
      case (state)
        SEARCH: if (v_edge) begin
          ref_len   <= line_len;
          ref_lines <= vlen;
          match_cnt <= MW'(1);
          state     <= VERIFY;
        end
        VERIFY: begin
          if (line_bad || frame_bad) state <= SEARCH;
          else if (go_lock)          state <= LOCKED;
          else if (v_edge)           match_cnt <= match_cnt + MW'(1);
        end
        LOCKED: if (line_bad || frame_bad || sat) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench: the line driver queues expected per-line/per-frame results,
// a negedge monitor pops and compares whenever the decoder pulses.
module tb_vga_sync_decoder;
  import vga_sync_pkg::*;

  // Full 682-clock lines, but only 8 lines per frame to keep runs short.
  localparam int LINE = H_TOTAL_DEF;
  localparam int HS   = H_SYNC_DEF;
  localparam int HIGH = LINE - HS;
  localparam int FR   = 8;
  localparam int VBP  = 3;
  localparam int VACT = 4;
  localparam int VS_FALL = FR - V_SYNC_DEF;

  typedef struct { logic [10:0] len; logic [10:0] y; logic lk; logic act; bit chk; } lrec_t;
  typedef struct { logic [10:0] lines; logic [10:0] len; logic lk; bit chk; } frec_t;

  logic clk = 1'b0, reset, hsync_n, vsync_n;
  logic [10:0] x, y, line_len, frame_lines;
  logic active, new_line, new_frame, locked;

  lrec_t lq[$];
  frec_t fq[$];
  logic [10:0] sq[$];

  int total = 0, bad = 0;
  int vcount, prev_high;
  bit first;
  logic rst_seen = 1'b0;

  vga_sync_decoder #(.V_BACKPORCH(VBP), .V_ACTIVE(VACT)) dut (
    .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .x(x), .y(y), .active(active), .new_line(new_line), .new_frame(new_frame),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= reset;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change 3 time units after the clock edge (asynchronous phase).
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic drive_line(input int idx, input int high, input int rst_at, input bit stop);
    lrec_t lr;
    frec_t fr;
    int meas;
    bit coinc;
    hsync_n = 1'b0;
    tick(HS);
    coinc = 1'b0;
    if (idx == 0) begin vsync_n = 1'b1; coinc = 1'b1; vcount++; end
    if (idx == VS_FALL) vsync_n = 1'b0;
    meas = prev_high + HS;
    if (prev_high != HIGH) vcount = 0;
    lr.len = 11'(meas);
    lr.y   = 11'(idx - VBP);
    lr.lk  = (vcount >= 3);
    lr.act = lr.lk && idx >= VBP && idx < VBP + VACT;
    lr.chk = !first;
    lq.push_back(lr);
    if (coinc) begin
      fr.lines = 11'(FR);
      fr.len   = 11'(meas);
      fr.lk    = lr.lk;
      fr.chk   = !first;
      fq.push_back(fr);
    end
    first = 1'b0;
    hsync_n = 1'b1;
    prev_high = high;
    if (stop) begin
      sq.push_back(11'(2047 - 32));
      tick(2100);
    end else if (rst_at > 0) begin
      tick(rst_at);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      first = 1'b1;
      vcount = 0;
      tick(high - rst_at - 2);
    end else begin
      tick(high);
    end
  endtask

  // Monitor
  initial begin
    lrec_t cur;
    frec_t fr;
    logic [10:0] sx;
    int off = -1;
    logic prev_lk = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("reset_x", x, 0);
        chk("reset_y", y, 0);
        chk("reset_len", line_len, 0);
        chk("reset_lines", frame_lines, 0);
        chk("reset_flags", {active, new_line, new_frame, locked}, 0);
        off = -1;
      end else begin
        if (new_line) begin
          if (lq.size() == 0) begin
            total++; bad++;
            $display("FAIL line_event: got unexpected new_line expected none");
          end else begin
            cur = lq.pop_front();
            if (cur.chk) chk("line_len", line_len, cur.len);
            chk("line_y", y, cur.y);
            chk("line_locked", locked, cur.lk);
            chk("line_x_start", x, 2016);
            off = 0;
          end
        end else if (off >= 0) begin
          off++;
          if (off == 31) begin
            chk("x_before_bp", x, 2047);
            chk("active_before_bp", active, 0);
          end
          if (off == 32) begin
            chk("x_at_bp", x, 0);
            chk("active_at_bp", active, cur.act);
            off = -1;
          end
        end
        if (new_frame) begin
          if (fq.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_event: got unexpected new_frame expected none");
          end else begin
            fr = fq.pop_front();
            chk("frame_lines", frame_lines, fr.lines);
            if (fr.chk) chk("frame_line_len", line_len, fr.len);
            chk("frame_locked", locked, fr.lk);
            chk("frame_y", y, 2045);
          end
        end
        if (prev_lk && !locked && !new_line && !new_frame) begin
          if (sq.size() == 0) begin
            total++; bad++;
            $display("FAIL lock_drop: got unexpected drop expected none");
          end else begin
            sx = sq.pop_front();
            chk("sat_x", x, sx);
            chk("sat_line_len", line_len, LINE);
          end
        end
      end
      prev_lk = locked;
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1;
    first = 1'b1; vcount = 0; prev_high = HIGH;
    tick(4);
    reset = 1'b0;
    tick(20);
    // Nominal timing: partial frame, then lock on the 3rd VSYNC edge and hold.
    for (int i = 1; i < FR; i++) drive_line(i, HIGH, 0, 1'b0);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < FR; i++) drive_line(i, HIGH, 0, 1'b0);
    // One 683-clock line, then relock over 3 clean frames.
    for (int i = 0; i < FR; i++) drive_line(i, (i == 3) ? HIGH + 1 : HIGH, 0, 1'b0);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < FR; i++) drive_line(i, HIGH, 0, 1'b0);
    // Reset mid-line while locked, relock, then stop HSYNC.
    drive_line(0, HIGH, 300, 1'b0);
    for (int i = 1; i < FR; i++) drive_line(i, HIGH, 0, 1'b0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < FR; i++) drive_line(i, HIGH, 0, 1'b0);
    drive_line(0, HIGH, 0, 1'b0);
    drive_line(1, HIGH, 0, 1'b0);
    drive_line(2, HIGH, 0, 1'b1);
    tick(10);
    chk("line_queue_left", lq.size(), 0);
    chk("frame_queue_left", fq.size(), 0);
    chk("sat_queue_left", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
